// File: rtl/boa_wbuf_if.sv
// Single-port memory bus used on both sides of the boa_wbuf posted write buffer.
// A request is accepted when (re or we nonzero) and ready; rdata follows one cycle later.
interface boa_wbuf_if #(
  parameter int ALEN = 16
);
  logic            re;
  logic [3:0]      we;
  logic [ALEN-1:0] addr;
  logic [31:0]     wdata;
  logic            ready;
  logic [31:0]     rdata;

  modport master (output re, we, addr, wdata, input ready, rdata);
  modport slave  (input re, we, addr, wdata, output ready, rdata);
endinterface

// File: rtl/boa_wbuf.sv
// Posted write buffer between the cache memory port and the external bus; reads wait for older writes.
// Optional macro BOA_WBUF_FWD_EN serves full-word reads from the youngest matching buffered write.
module boa_wbuf #(
  parameter int ALEN  = 16,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  boa_wbuf_if.slave   up,
  boa_wbuf_if.master  dn,
  output logic        wb_empty
);
  localparam int PW = $clog2(DEPTH);

  // Extra pointer MSB distinguishes full from empty when the slot bits are equal.
  logic [PW:0]     wr_ptr, rd_ptr;
  logic [PW-1:0]   head, tail;
  logic [ALEN-1:0] mem_addr  [DEPTH];
  logic [3:0]      mem_we    [DEPTH];
  logic [31:0]     mem_wdata [DEPTH];

  logic        empty, full, pop, push, pass_rd;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic        rsel_q;
  logic [31:0] rdata_q;

  assign head  = rd_ptr[PW-1:0];
  assign tail  = wr_ptr[PW-1:0];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (head == tail);

`ifdef BOA_WBUF_FWD_EN
  logic [PW:0] count;
  assign count = wr_ptr - rd_ptr;

  // Scan oldest to youngest so the last match seen is the youngest entry.
  always_comb begin
    logic          hit_full;
    logic [PW-1:0] slot;
    hit_full = 1'b0;
    fwd_data = '0;
    slot     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head + PW'(i);
      if (((PW+1)'(i) < count) && (mem_addr[slot] == up.addr)) begin
        hit_full = (mem_we[slot] == 4'hf);
        fwd_data = mem_wdata[slot];
      end
    end
    fwd_hit = hit_full && up.re && (up.we == 4'h0);
  end
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  // NOTE: every output gets a default first so no path through this block can infer a latch.
  always_comb begin
    dn.re    = 1'b0;
    dn.we    = 4'h0;
    dn.addr  = '0;
    dn.wdata = '0;
    up.ready = 1'b0;
    pass_rd  = 1'b0;
    if (!rst) begin
      if (!empty) begin
        dn.we    = mem_we[head];
        dn.addr  = mem_addr[head];
        dn.wdata = mem_wdata[head];
        if (up.re) up.ready = fwd_hit;
        else       up.ready = !full || dn.ready;
      end else if (up.re) begin
        // Empty buffer: the access, including any combined write, goes straight through.
        dn.re    = 1'b1;
        dn.we    = up.we;
        dn.addr  = up.addr;
        dn.wdata = up.wdata;
        up.ready = dn.ready;
        pass_rd  = dn.ready;
      end else begin
        up.ready = 1'b1;
      end
    end
  end

  assign pop  = !empty && dn.ready;
  assign push = up.ready && !up.re && (up.we != 4'h0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rsel_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      rsel_q  <= pass_rd;
      rdata_q <= fwd_hit ? fwd_data : 32'h0;
    end
  end

  // NOTE: storage is not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[tail]  <= up.addr;
      mem_we[tail]    <= up.we;
      mem_wdata[tail] <= up.wdata;
    end
  end

  assign up.rdata = rsel_q ? dn.rdata : rdata_q;
  assign wb_empty = empty;

endmodule

// File: doc/boa_wbuf.md
Name: boa_wbuf

Overview:
- Posted write buffer between the cache's external-memory port (upstream) and the external memory bus (downstream).
- Absorbs cache write-backs into a small in-order FIFO so that the cache does not stall on memory write latency.
- Reads pass straight through once all older writes have drained, which keeps memory ordering strict.
- Same bus protocol on both sides: a request is accepted in the cycle where (re or we nonzero) and ready=1; read data is valid on rdata in the following cycle.

Parameters:
ALEN, 16, word-address width of both buses
DEPTH, 4, FIFO entries; power of two, ≥2

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
up_re  input  1  upstream read request
up_we  input  4  upstream byte write enables
up_addr  input  ALEN  upstream word address
up_wdata  input  32  upstream write data
up_ready  output  1  upstream request accepted this cycle
up_rdata  output  32  upstream read data, valid cycle after accepted read
dn_re  output  1  downstream read request
dn_we  output  4  downstream byte write enables
dn_addr  output  ALEN  downstream word address
dn_wdata  output  32  downstream write data
dn_ready  input  1  downstream accepts request this cycle
dn_rdata  input  32  downstream read data, valid cycle after accepted read
wb_empty  output  1  FIFO holds no pending writes (used for fences)

Behaviour:
- FIFO storage:
  - Each entry holds {addr, we, wdata}.
  - Read/write pointers of log2(DEPTH)+1 bits, so full and empty are unambiguous.
  - Pointers wrap modulo 2·DEPTH.
- Reset (async, rst=1):
  - Pointers and count cleared, so wb_empty=1.
  - up_ready=0; dn_re=0, dn_we=0, dn_addr=0, dn_wdata=0; up_rdata register cleared to 0.
  - A drain in flight at reset is dropped; there is no partial-entry state.
- Pure write (up_we≠0, up_re=0):
  - up_ready = !full or (full and pop this cycle).
  - Pop this cycle = FIFO non-empty and dn_ready.
  - On acceptance the write is pushed at the tail; it becomes visible downstream no earlier than the next cycle.
  - This gives a combinational path dn_ready→up_ready.
- Drain:
  - While non-empty, the head drives dn_we/dn_addr/dn_wdata with dn_re=0.
  - Pop on dn_ready. Writes leave strictly in arrival order.
- Read (up_re=1, any up_we), FIFO non-empty:
  - up_ready=0 and the request is not forwarded downstream; the buffer keeps draining.
- Read, FIFO empty:
  - Pass-through: dn_re=up_re, dn_we=up_we, dn_addr=up_addr, dn_wdata=up_wdata, up_ready=dn_ready.
  - The read+write combination (re=1, we≠0) passes through as one access and is never buffered.
- Read response:
  - Response-select flag registered on each accepted read.
  - up_rdata = dn_rdata in the cycle after a pass-through read.
  - Otherwise up_rdata = forwarded register (see optional feature), else 0.
- Idle (up_re=0, up_we=0, FIFO empty): all dn_* = 0; up_ready=1.
- Simultaneous push and pop:
  - Count unchanged.
  - When DEPTH=1 remains or the FIFO is full, the pop frees the slot used by the push in the same edge.
- wb_empty = (count==0), registered-pointer derived, no combinational dependency on inputs.

Optional Feature:
- Macro BOA_WBUF_FWD_EN.
- Defined: a read with up_we=0 whose address matches a buffered entry is served from the buffer.
  - Match uses the newest matching entry (youngest wins).
  - If that entry has we=4'hf: up_ready=1 that cycle, and up_rdata = entry wdata the next cycle. No downstream access.
  - If the newest match has partial byte enables: stall as in the non-forwarding case.
  - Non-matching reads still stall until empty.
- Undefined: no address comparators; all reads with FIFO non-empty stall until drained.

Test Plan:
- Reset mid-drain: 3 writes queued, rst pulse → wb_empty=1, dn_we=0, up_ready=0 during rst, 1 after for a write.
- Write burst with dn_ready=0: 4 writes {addr 2,3,4,5, we=f} → up_ready 1,1,1,1, then 0 on 5th. Raise dn_ready → dn_addr 2,3,4,5 in order, one per cycle; 5th write accepted in the first drain cycle.
- Read after write: write addr 2 data dead_beef, then read addr 18, dn_ready=1 → up_ready=0 for one cycle (drain), then dn_re=1 addr 18, up_rdata=dn_rdata next cycle.
- Read+write combo with empty FIFO: re=1, we=1, addr 2 → passes through in the same cycle, wb_empty stays 1.
- Full boundary with simultaneous pop: FIFO full, dn_ready=1, new write → up_ready=1, count stays 4; pointers wrap correctly over 10 cycles.
- With BOA_WBUF_FWD_EN, dn_ready=0:
  - Write addr 34 we=f data 12345678, read 34 → up_ready=1, up_rdata=12345678 next cycle, dn_re=0.
  - Read 34 after a later write of addr 34 with we=3 → stall.
